// File: rtl/stream_packet_assembler.sv
// stream_packet_assembler: gathers an MSB-first byte stream into
// PKT_WIDTH-bit packets behind a double-buffered valid/ready output.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     byte available
//   in_ready     byte accepted when in_valid && in_ready
//   in_data      received byte
//   out_valid    assembled packet held in the output slot
//   out_ready    downstream accepts the packet
//   out_data     assembled packet (low PKT_WIDTH bits of the bytes)
//   busy         partial packet in progress
//   timeout_err  one-cycle pulse when a stale partial packet is dropped
module stream_packet_assembler #(
    parameter int PKT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PKT_WIDTH-1:0] out_data,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int NUM_BYTES = (PKT_WIDTH + 7) / 8;
    localparam int SW = 8 * NUM_BYTES;
    localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);
    localparam logic [TW-1:0] TLIM =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    logic [CW-1:0] cnt;
    logic [SW-1:0] sh;
    logic [SW-1:0] sh_next;
    logic [TW-1:0] tcnt;
    logic          is_last;
    logic          accept;
    logic          load;
    logic          idle;
    logic          expire;

    always_comb begin
        is_last  = (cnt == LAST);
        // Only the final byte can be refused: it needs the output slot.
        in_ready = !rst && !(is_last && out_valid && !out_ready);
        accept   = in_valid && in_ready;
        load     = accept && is_last;
        // A refused final byte keeps in_valid high, so stalls never count.
        idle     = (cnt != '0) && !in_valid;
        // Fires on the idle cycle that completes TIMEOUT_CYCLES idle cycles.
        expire   = TO_EN && idle && (tcnt == TLIM);
        // Bytes beyond the packet width fall off the top.
        sh_next  = SW'({sh, in_data});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            sh          <= '0;
            tcnt        <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
            if (load) begin
                cnt       <= '0;
                sh        <= '0;
                out_data  <= sh_next[PKT_WIDTH-1:0];
                out_valid <= 1'b1;
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if (accept) begin
                    cnt <= cnt + 1'b1;
                    sh  <= sh_next;
                end else if (expire) begin
                    cnt <= '0;
                    sh  <= '0;
                end
            end
            if (accept || expire || cnt == '0) begin
                tcnt <= '0;
            end else if (TO_EN && idle) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: tb/tb_stream_packet_assembler.sv
// Testbench for stream_packet_assembler: four parameterisations share
// one stimulus stream; table vectors plus a randomized model comparison.
module tb_stream_packet_assembler;

    typedef struct {
        int          k;
        bit          r;
        bit          v;
        logic [7:0]  d;
        bit          o;
        bit          eir;
        bit          eov;
        logic [31:0] eod;
        bit          eb;
        bit          ee;
    } row_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;

    logic        ir [4];
    logic        ov [4];
    logic        bz [4];
    logic        te [4];
    logic [31:0] od [4];
    logic [11:0] od0;
    logic [15:0] od1;
    logic [19:0] od2;
    logic [7:0]  od3;

    int W  [4] = '{12, 16, 20, 8};
    int TO [4] = '{0, 4, 3, 0};

    int          mn   [4];
    int          mb   [4][4];
    bit          hv   [4];
    logic [31:0] hd   [4];
    int          idle [4];
    bit          merr [4];

    int checks   = 0;
    int failures = 0;

    row_t rows[$];
    row_t nul;

    always #5 clk = ~clk;

    stream_packet_assembler #(.PKT_WIDTH(12), .TIMEOUT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od0), .busy(bz[0]), .timeout_err(te[0]));
    stream_packet_assembler #(.PKT_WIDTH(16), .TIMEOUT_CYCLES(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od1), .busy(bz[1]), .timeout_err(te[1]));
    stream_packet_assembler #(.PKT_WIDTH(20), .TIMEOUT_CYCLES(3)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od2), .busy(bz[2]), .timeout_err(te[2]));
    stream_packet_assembler #(.PKT_WIDTH(8), .TIMEOUT_CYCLES(0)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
        .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready),
        .out_data(od3), .busy(bz[3]), .timeout_err(te[3]));

    assign od[0] = 32'(od0);
    assign od[1] = 32'(od1);
    assign od[2] = 32'(od2);
    assign od[3] = 32'(od3);

    function automatic row_t R(int k, bit r, bit v, logic [7:0] d, bit o,
                               bit eir, bit eov, logic [31:0] eod,
                               bit eb, bit ee);
        row_t x;
        x.k = k; x.r = r; x.v = v; x.d = d; x.o = o;
        x.eir = eir; x.eov = eov; x.eod = eod; x.eb = eb; x.ee = ee;
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_step(int k, bit rdy);
        int nb;
        logic [63:0] p;
        nb = (W[k] + 7) / 8;
        if (rst) begin
            mn[k] = 0; hv[k] = 0; hd[k] = 0; idle[k] = 0; merr[k] = 0;
        end else begin
            merr[k] = 0;
            hv[k] = hv[k] && !out_ready;
            if (in_valid && rdy) begin
                mb[k][mn[k]] = int'(in_data);
                mn[k]++;
                idle[k] = 0;
                if (mn[k] == nb) begin
                    p = 0;
                    for (int i = 0; i < nb; i++) p = p * 256 + 64'(mb[k][i]);
                    p = p & ((64'd1 << W[k]) - 1);
                    hd[k] = p[31:0];
                    hv[k] = 1;
                    mn[k] = 0;
                end
            end else if (mn[k] != 0 && !in_valid) begin
                idle[k]++;
                if (TO[k] > 0 && idle[k] == TO[k]) begin
                    mn[k] = 0;
                    merr[k] = 1;
                end
            end
            if (mn[k] == 0) idle[k] = 0;
        end
    endtask

    task automatic cyc(bit tab, row_t rr);
        bit rdy [4];
        int nb;
        #2;
        for (int k = 0; k < 4; k++) begin
            nb = (W[k] + 7) / 8;
            rdy[k] = !rst && !(mn[k] == nb - 1 && hv[k] && !out_ready);
            chk($sformatf("m%0d_in_ready", k), 32'(ir[k]), 32'(rdy[k]));
        end
        if (tab) chk($sformatf("t%0d_in_ready", rr.k), 32'(ir[rr.k]), 32'(rr.eir));
        @(posedge clk);
        for (int k = 0; k < 4; k++) model_step(k, rdy[k]);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("m%0d_out_valid", k), 32'(ov[k]), 32'(hv[k]));
            chk($sformatf("m%0d_out_data", k), od[k], hd[k]);
            chk($sformatf("m%0d_busy", k), 32'(bz[k]), 32'(mn[k] != 0));
            chk($sformatf("m%0d_timeout_err", k), 32'(te[k]), 32'(merr[k]));
        end
        if (tab) begin
            chk($sformatf("t%0d_out_valid", rr.k), 32'(ov[rr.k]), 32'(rr.eov));
            if (rr.eov) chk($sformatf("t%0d_out_data", rr.k), od[rr.k], rr.eod);
            chk($sformatf("t%0d_busy", rr.k), 32'(bz[rr.k]), 32'(rr.eb));
            chk($sformatf("t%0d_timeout_err", rr.k), 32'(te[rr.k]), 32'(rr.ee));
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            mn[k] = 0; hv[k] = 0; hd[k] = 0; idle[k] = 0; merr[k] = 0;
        end
        nul = R(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);

        // 12-bit packet, padding nibble of first byte dropped
        rows.push_back(R(0, 1, 0, 8'h00, 1, 0, 0, 0,       0, 0));
        rows.push_back(R(0, 0, 1, 8'hA5, 1, 1, 0, 0,       1, 0));
        rows.push_back(R(0, 0, 1, 8'h3C, 1, 1, 1, 32'h53C, 0, 0));
        rows.push_back(R(0, 0, 0, 8'h00, 1, 1, 0, 0,       0, 0));
        // held packet, stalled final byte, drain and load together
        rows.push_back(R(1, 1, 0, 8'h00, 0, 0, 0, 0,        0, 0));
        rows.push_back(R(1, 0, 1, 8'h12, 0, 1, 0, 0,        1, 0));
        rows.push_back(R(1, 0, 1, 8'h34, 0, 1, 1, 32'h1234, 0, 0));
        rows.push_back(R(1, 0, 1, 8'h56, 0, 1, 1, 32'h1234, 1, 0));
        rows.push_back(R(1, 0, 1, 8'h78, 0, 0, 1, 32'h1234, 1, 0));
        rows.push_back(R(1, 0, 1, 8'h78, 0, 0, 1, 32'h1234, 1, 0));
        rows.push_back(R(1, 0, 1, 8'h78, 1, 1, 1, 32'h5678, 0, 0));
        rows.push_back(R(1, 0, 0, 8'h00, 1, 1, 0, 0,        0, 0));
        // continuous stream, one packet every two cycles
        rows.push_back(R(1, 1, 0, 8'h00, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                rows.push_back(R(1, 0, 1, 8'(i), 1, 1, 0, 0, 1, 0));
            else
                rows.push_back(R(1, 0, 1, 8'(i), 1, 1, 1,
                                 32'((i - 1) * 256 + i), 0, 0));
        end
        // timeout drops a lone byte after four idle cycles
        rows.push_back(R(1, 1, 0, 8'h00, 1, 0, 0, 0,        0, 0));
        rows.push_back(R(1, 0, 1, 8'hAA, 1, 1, 0, 0,        1, 0));
        rows.push_back(R(1, 0, 0, 8'h00, 1, 1, 0, 0,        1, 0));
        rows.push_back(R(1, 0, 0, 8'h00, 1, 1, 0, 0,        1, 0));
        rows.push_back(R(1, 0, 0, 8'h00, 1, 1, 0, 0,        1, 0));
        rows.push_back(R(1, 0, 0, 8'h00, 1, 1, 0, 0,        0, 1));
        rows.push_back(R(1, 0, 0, 8'h00, 1, 1, 0, 0,        0, 0));
        rows.push_back(R(1, 0, 1, 8'h11, 1, 1, 0, 0,        1, 0));
        rows.push_back(R(1, 0, 1, 8'h22, 1, 1, 1, 32'h1122, 0, 0));
        rows.push_back(R(1, 0, 0, 8'h00, 1, 1, 0, 0,        0, 0));
        // back-pressure is not idle time
        rows.push_back(R(1, 1, 0, 8'h00, 0, 0, 0, 0,        0, 0));
        rows.push_back(R(1, 0, 1, 8'h01, 0, 1, 0, 0,        1, 0));
        rows.push_back(R(1, 0, 1, 8'h02, 0, 1, 1, 32'h0102, 0, 0));
        rows.push_back(R(1, 0, 1, 8'h03, 0, 1, 1, 32'h0102, 1, 0));
        for (int i = 0; i < 10; i++)
            rows.push_back(R(1, 0, 1, 8'h04, 0, 0, 1, 32'h0102, 1, 0));
        rows.push_back(R(1, 0, 1, 8'h04, 1, 1, 1, 32'h0304, 0, 0));
        rows.push_back(R(1, 0, 0, 8'h00, 1, 1, 0, 0,        0, 0));
        // reset mid-packet with a packet held
        rows.push_back(R(1, 1, 0, 8'h00, 0, 0, 0, 0,        0, 0));
        rows.push_back(R(1, 0, 1, 8'h12, 0, 1, 0, 0,        1, 0));
        rows.push_back(R(1, 0, 1, 8'h34, 0, 1, 1, 32'h1234, 0, 0));
        rows.push_back(R(1, 0, 1, 8'h12, 0, 1, 1, 32'h1234, 1, 0));
        rows.push_back(R(1, 1, 0, 8'h00, 0, 0, 0, 0,        0, 0));
        rows.push_back(R(1, 0, 1, 8'h9A, 1, 1, 0, 0,        1, 0));
        rows.push_back(R(1, 0, 1, 8'hBC, 1, 1, 1, 32'h9ABC, 0, 0));
        rows.push_back(R(1, 0, 0, 8'h00, 1, 1, 0, 0,        0, 0));

        foreach (rows[i]) begin
            rst       = rows[i].r;
            in_valid  = rows[i].v;
            in_data   = rows[i].d;
            out_ready = rows[i].o;
            cyc(1, rows[i]);
        end

        for (int n = 0; n < 4000; n++) begin
            int vp;
            vp = ((n / 400) % 3 == 0) ? 90 : (((n / 400) % 3 == 1) ? 50 : 10);
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 99) < vp);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 99) < 65);
            cyc(0, nul);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_packet_assembler.md
Name: stream_packet_assembler

Overview:
- Upstream neighbour of the network source stage: gathers a byte stream from the host link (UART/FIFO receive path) into full-width packets.
- Presents each packet on a valid/ready interface sized PKT_WIDTH. The network source stage consumes this packet as its flag prefix plus input charges.
- Double-buffered, so byte reception continues while a finished packet waits for the network to accept it.
- Optional inter-byte timeout discards stale partial packets to resynchronise framing.

Parameters:
- PKT_WIDTH, 16, packet width in bits (≥1); NUM_BYTES = ceil(PKT_WIDTH/8).
- TIMEOUT_CYCLES, 0, idle cycles with a partial packet before it is discarded; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  byte available.
- in_ready  output  1  byte accepted this cycle when in_valid && in_ready.
- in_data  input  8  received byte.
- out_valid  output  1  assembled packet held.
- out_ready  input  1  downstream accepts packet.
- out_data  output  PKT_WIDTH  assembled packet.
- busy  output  1  partial packet in progress (byte count ≠ 0).
- timeout_err  output  1  one-cycle pulse when a partial packet is discarded.

Behaviour:
- Reset (rst high at a rising edge) clears the byte counter, shift register, output register, out_valid, busy, timeout_err and the timeout counter. This takes effect mid-packet and mid-handshake: the partial or held packet is lost. in_ready is low during the rst cycle, and 1 on the first cycle after reset.
- Byte order is MSB-first. The first byte of a packet is most significant. The concatenation of NUM_BYTES bytes, truncated to its low PKT_WIDTH bits, forms the packet. The top 8*NUM_BYTES-PKT_WIDTH bits of the first byte are padding and are ignored.
- The byte counter cnt runs 0..NUM_BYTES-1. An accepted non-final byte is shifted into the assembly register and cnt increments.
- The final byte (cnt == NUM_BYTES-1) is accepted only when the output slot is free or draining: in_ready = !(cnt==NUM_BYTES-1 && out_valid && !out_ready). Non-final bytes are always accepted.
- On acceptance of the final byte:
  - The full packet (including this byte) loads into out_data.
  - out_valid is set at the next edge and cnt wraps to 0.
  - Latency is one cycle from the final byte's handshake to out_valid.
- out_valid clears after out_valid && out_ready unless a new packet loads in the same cycle. On a simultaneous drain and load, out_valid stays 1 with new data, giving back-to-back packets at one per NUM_BYTES input cycles.
- out_data and out_valid are registered and stable while out_valid && !out_ready.
- NUM_BYTES == 1: every accepted byte is a final byte.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter increments each cycle in which cnt ≠ 0 and no byte is accepted. It resets to 0 on any accepted byte or when cnt == 0.
  - When it reaches TIMEOUT_CYCLES, at the next edge: cnt←0, shift register cleared, timeout_err pulses for one cycle, and the counter returns to 0.
  - A byte accepted in the same cycle the count is reached takes priority: no discard occurs.
  - The held output packet is never affected by a timeout.
- Stalled final byte: the timeout counter does not advance while in_valid is high and the byte is being refused, so back-pressure is never treated as idle.
- busy = (cnt ≠ 0), registered.

Test Plan:
- PKT_WIDTH=12, out_ready=1: bytes 0xA5, 0x3C back-to-back → out_data=0x53C, out_valid high for exactly one cycle, one cycle after the 0x3C handshake; busy high for one cycle between the bytes.
- PKT_WIDTH=16, out_ready=0: send 0x12,0x34, then 0x56,0x78 → first packet 0x1234 held. 0x56 is accepted; in_ready drops with 0x78 pending. Raising out_ready makes 0x1234 transfer, 0x78 is accepted the same cycle, and 0x5678 is valid the next cycle.
- PKT_WIDTH=16, out_ready=1, continuous bytes 0x00..0x07 → packets 0x0001, 0x0203, 0x0405, 0x0607, one every 2 cycles, no bubbles.
- TIMEOUT_CYCLES=4, PKT_WIDTH=16: send 0xAA, then idle → timeout_err pulses once, 4 cycles after the byte's acceptance edge, busy falls. Then 0x11, 0x22 → out_data=0x1122 (0xAA not present).
- TIMEOUT_CYCLES=4, out_valid held with out_ready=0: partial byte plus final byte stalled for 10 cycles → no timeout_err; on release, the packet completes correctly.
- Reset mid-packet: after byte 0x12 with out_valid=1, assert rst for one cycle → out_valid=0, busy=0. The next two bytes 0x9A, 0xBC give 0x9ABC.
